// File: rtl/cpu_defs_pkg.sv
// ----------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the core's memory-side bridges.
//   state_t : FSM state encoding for the SRAM-like bridges
//             (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   SZ_*    : access size codes carried on cpu_size / data_size
// ----------------------------------------------------------------------------
package cpu_defs_pkg;

    // Bridge FSM states; the numeric encoding is fixed because other
    // blocks in the core decode it directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Access size codes shared by the core and the bus.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge.sv
// ----------------------------------------------------------------------------
// data_sram_like_bridge
// Turns the core's single-cycle data SRAM port into a split-transaction
// SRAM-like bus (req / addr_ok / data_ok). The core is stalled while an
// access is outstanding, and load data is held in cpu_rdata until the
// pipeline moves on, so a multi-cycle memory can sit behind the core.
//
// Ports
//   clk, resetn        core clock, asynchronous active-low reset
//   cpu_en             core requests a data access this cycle
//   cpu_wen[3:0]       byte write enables (nonzero = store)
//   cpu_size[1:0]      0 byte, 1 half, 2 word
//   cpu_addr           byte address
//   cpu_wdata          lane-aligned store data
//   cpu_hold           MEM/WB held by another source
//   cpu_rdata          captured load data
//   cpu_stall          access not complete, core must freeze
//   data_req           bus request valid
//   data_wr            1 = write
//   data_size          latched access size
//   data_addr          latched address
//   data_wdata         latched store data
//   data_addr_ok       bus accepted the request
//   data_data_ok       bus returns read data / write completion
//   data_rdata         bus read data, valid with data_data_ok
// ----------------------------------------------------------------------------
module data_sram_like_bridge
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_t state;

    // Request FSM and request register bank. The request fields are only
    // loaded in IDLE, so whatever the core does while frozen cannot disturb
    // an accepted or pending request. A data_ok seen in REQ without the
    // address handshake is a protocol violation and is deliberately ignored;
    // a data_ok seen in IDLE (e.g. left over from an access aborted by reset)
    // is ignored as well. Stores complete without touching cpu_rdata.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= SZ_BYTE;
            data_addr  <= '0;
            data_wdata <= '0;
            cpu_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_en) begin
                        data_addr  <= cpu_addr;
                        data_wdata <= cpu_wdata;
                        data_size  <= cpu_size;
                        data_wr    <= |cpu_wen;
                        data_req   <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            if (!data_wr) begin
                                cpu_rdata <= data_rdata;
                            end
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        if (!data_wr) begin
                            cpu_rdata <= data_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!cpu_hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall is combinational so the core freezes in the very cycle it
    // presents a new access; DONE is the only cycle in which the
    // instruction is allowed to complete.
    assign cpu_stall = (state == IDLE) ? cpu_en : (state != DONE);

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// ----------------------------------------------------------------------------
// tb_data_sram_like_bridge
// Self-checking bench for data_sram_like_bridge. Each scenario task drives
// the core and bus sides cycle by cycle. Expected load results are pushed to
// a scoreboard queue when the access is issued and popped when the bridge
// completes (first DONE cycle). A background monitor checks that no new
// request is raised while a transaction is outstanding.
// ----------------------------------------------------------------------------
module tb_data_sram_like_bridge;
    import cpu_defs_pkg::*;

    logic        clk;
    logic        resetn;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_hold;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int          total;
    int          bad;
    int          req_cycles;
    logic        outstanding;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;

    data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_en       (cpu_en),
        .cpu_wen      (cpu_wen),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_hold     (cpu_hold),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    // 10 ns core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-side monitor sampled mid-cycle: a request while a transaction is
    // already in flight means more than one outstanding access.
    always @(negedge clk) begin
        if (!resetn) begin
            outstanding = 1'b0;
        end else begin
            if (data_req) begin
                req_cycles++;
                total++;
                if (outstanding) begin
                    bad++;
                    $display("[TB] FAIL overlap: data_req=1 while outstanding=1, want no request");
                end
                if (data_data_ok && !data_addr_ok) begin
                    $display("[TB] note: bus protocol violation (data_ok without addr_ok in REQ)");
                end
            end
            if (data_req && data_addr_ok && !data_data_ok) outstanding = 1'b1;
            if (data_data_ok) outstanding = 1'b0;
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the scoreboard and compare it with the captured load data.
    task automatic pop_expect(input string name);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s: scoreboard empty, got rdata=%h", name, cpu_rdata);
        end else begin
            exp_val = exp_q.pop_front();
            if (cpu_rdata !== exp_val) begin
                bad++;
                $display("[TB] FAIL %s: cpu_rdata=%h want %h", name, cpu_rdata, exp_val);
            end
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        resetn = 1'b0; cpu_en = 1'b0; cpu_wen = 4'b0; cpu_size = 2'd0;
        cpu_addr = '0; cpu_wdata = '0; cpu_hold = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        #2;
        total++;
        if ({data_req, data_wr, data_size} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: req/wr/size=%b want 0000", {data_req, data_wr, data_size});
        end
        total++;
        if ({data_addr, data_wdata, cpu_rdata} !== 96'd0) begin
            bad++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", data_addr, data_wdata, cpu_rdata);
        end
        total++;
        if (dut.state !== IDLE || cpu_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: state=%0d stall=%b want 0 0", dut.state, cpu_stall);
        end
        cpu_en = 1'b1;
        #1;
        total++;
        if (cpu_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_stall_en: stall=%b want 1", cpu_stall);
        end
        cpu_en = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_load_zero_wait();
        $display("[TB] test_load_zero_wait");
        tick();
        cpu_en = 1'b1; cpu_wen = 4'b0; cpu_size = 2'd2; cpu_addr = 32'h8000_0010;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        total++;
        if (cpu_stall !== 1'b1 || data_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_c0: stall=%b req=%b want 1 0", cpu_stall, data_req);
        end
        tick();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if (data_req !== 1'b1 || cpu_stall !== 1'b1 || data_wr !== 1'b0 ||
            data_addr !== 32'h8000_0010 || data_size !== 2'd2) begin
            bad++;
            $display("[TB] FAIL load_c1: req=%b stall=%b wr=%b addr=%h size=%0d want 1 1 0 80000010 2",
                     data_req, cpu_stall, data_wr, data_addr, data_size);
        end
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        #1;
        total++;
        if (cpu_stall !== 1'b0 || data_req !== 1'b0 || dut.state !== DONE) begin
            bad++;
            $display("[TB] FAIL load_c2: stall=%b req=%b state=%0d want 0 0 3", cpu_stall, data_req, dut.state);
        end
        pop_expect("load_rdata");
        tick();
        cpu_en = 1'b0;
        #1;
        total++;
        if (dut.state !== IDLE || cpu_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL load_c3: state=%0d rdata=%h want 0 deadbeef", dut.state, cpu_rdata);
        end
    endtask

    task automatic test_store_wait();
        $display("[TB] test_store_wait");
        tick();
        cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_size = 2'd0;
        cpu_addr = 32'h8000_0022; cpu_wdata = 32'h00AB_0000;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        total++;
        if (cpu_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL store_c0: stall=%b want 1", cpu_stall);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            // Scramble the core side: latched fields must not follow it.
            cpu_addr = $urandom; cpu_wdata = $urandom; cpu_size = 2'd2; cpu_wen = 4'b1111;
            data_addr_ok = (i == 3);
            #1;
            total++;
            if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd0 ||
                data_addr !== 32'h8000_0022 || data_wdata !== 32'h00AB_0000 || cpu_stall !== 1'b1) begin
                bad++;
                $display("[TB] FAIL store_req%0d: req=%b wr=%b size=%0d addr=%h wdata=%h stall=%b want 1 1 0 80000022 00ab0000 1",
                         i, data_req, data_wr, data_size, data_addr, data_wdata, cpu_stall);
            end
        end
        tick();
        data_addr_ok = 1'b0;
        #1;
        total++;
        if (data_req !== 1'b0 || cpu_stall !== 1'b1 || dut.state !== WAIT) begin
            bad++;
            $display("[TB] FAIL store_wait: req=%b stall=%b state=%0d want 0 1 2", data_req, cpu_stall, dut.state);
        end
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        #1;
        total++;
        if (cpu_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL store_dataok: stall=%b want 1", cpu_stall);
        end
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        #1;
        total++;
        if (cpu_stall !== 1'b0 || dut.state !== DONE) begin
            bad++;
            $display("[TB] FAIL store_done: stall=%b state=%0d want 0 3", cpu_stall, dut.state);
        end
        pop_expect("store_rdata_kept");
        tick();
        cpu_en = 1'b0; cpu_wen = 4'b0;
        #1;
    endtask

    task automatic test_hold();
        $display("[TB] test_hold");
        tick();
        cpu_en = 1'b1; cpu_wen = 4'b0; cpu_size = 2'd2; cpu_addr = 32'h8000_0030;
        exp_q.push_back(32'h1234_5678);
        tick();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        cpu_hold = 1'b1;
        #1;
        pop_expect("hold_rdata");
        for (int k = 0; k < 5; k++) begin
            total++;
            if (dut.state !== DONE || cpu_stall !== 1'b0 || data_req !== 1'b0 ||
                cpu_rdata !== 32'h1234_5678) begin
                bad++;
                $display("[TB] FAIL hold%0d: state=%0d stall=%b req=%b rdata=%h want 3 0 0 12345678",
                         k, dut.state, cpu_stall, data_req, cpu_rdata);
            end
            tick();
        end
        cpu_hold = 1'b0; cpu_en = 1'b0;
        tick();
        total++;
        if (dut.state !== IDLE || data_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_release: state=%0d req=%b want 0 0", dut.state, data_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] val;
        int          req_before;
        $display("[TB] test_back_to_back");
        req_before = req_cycles;
        cpu_wen = 4'b0; cpu_size = 2'd2;
        for (int a = 0; a < 4; a++) begin
            val = 32'hA5A5_0000 + 32'(a * 32'h111);
            cpu_en = 1'b1; cpu_addr = 32'h8000_0100 + 32'(a * 4);
            exp_q.push_back(val);
            #1;
            total++;
            if (cpu_stall !== 1'b1 || data_req !== 1'b0 || dut.state !== IDLE) begin
                bad++;
                $display("[TB] FAIL b2b%0d_c0: stall=%b req=%b state=%0d want 1 0 0", a, cpu_stall, data_req, dut.state);
            end
            tick();
            data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = val;
            #1;
            total++;
            if (data_req !== 1'b1 || data_addr !== 32'h8000_0100 + 32'(a * 4)) begin
                bad++;
                $display("[TB] FAIL b2b%0d_c1: req=%b addr=%h want 1 %h", a, data_req, data_addr, 32'h8000_0100 + 32'(a * 4));
            end
            tick();
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
            #1;
            total++;
            if (cpu_stall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL b2b%0d_c2: stall=%b want 0", a, cpu_stall);
            end
            pop_expect("b2b_rdata");
            tick();
        end
        cpu_en = 1'b0;
        #1;
        total++;
        if (req_cycles - req_before !== 4) begin
            bad++;
            $display("[TB] FAIL b2b_req_count: got %0d want 4", req_cycles - req_before);
        end
    endtask

    task automatic test_protocol_violation();
        $display("[TB] test_protocol_violation");
        tick();
        cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h8000_0200;
        exp_q.push_back(32'h55AA_55AA);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        #1;
        total++;
        if (dut.state !== REQ || data_req !== 1'b1 || cpu_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL viol_ignored: state=%0d req=%b stall=%b want 1 1 1", dut.state, data_req, cpu_stall);
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h55AA_55AA;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        #1;
        pop_expect("viol_rdata");
        tick();
        cpu_en = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_wait();
        $display("[TB] test_reset_mid_wait");
        tick();
        cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h8000_0300;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        total++;
        if (dut.state !== WAIT) begin
            bad++;
            $display("[TB] FAIL rst_pre: state=%0d want 2", dut.state);
        end
        resetn = 1'b0; cpu_en = 1'b0;
        #1;
        total++;
        if (dut.state !== IDLE || data_req !== 1'b0 || cpu_rdata !== 32'd0 ||
            data_addr !== 32'd0 || cpu_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_async: state=%0d req=%b rdata=%h addr=%h stall=%b want 0 0 0 0 0",
                     dut.state, data_req, cpu_rdata, data_addr, cpu_stall);
        end
        tick();
        resetn = 1'b1;
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        #1;
        total++;
        if (dut.state !== IDLE || cpu_rdata !== 32'd0 || data_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_stray: state=%0d rdata=%h req=%b want 0 0 0", dut.state, cpu_rdata, data_req);
        end
    endtask

    // Guard against a run that never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0; bad = 0; req_cycles = 0; outstanding = 1'b0;
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_hold();
        test_back_to_back();
        test_protocol_violation();
        test_reset_mid_wait();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
